alu_seq_ctrl: RTL
=================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle instruction sequencer for the 4-bit ALU + register-file datapath.
//  - Accepts one instruction at a time over a valid/ready handshake.
//  - Steps the datapath through READ -> EXEC -> WB.
//  - Drives register-file read addresses, operand/result latch enables, the ALU opcode and flag capture.
//  - Issues a one-hot per-register write-select for the register file's write-enable inputs.
// PARAMETERS
//  NUM_REGS  4  registers in the file; one rf_wsel bit per register
//  ADDR_W    2  register address width; must satisfy 2**ADDR_W >= NUM_REGS
//  DATA_W    4  datapath and immediate width
// PORTS
//  clk          in   1         clock; all state updates on posedge
//  reset        in   1         synchronous, active-high
//  instr_valid  in   1         instruction offered
//  instr_ready  out  1         controller can accept an instruction
//  instr_op     in   3         opcode (encoding below)
//  instr_rd     in   ADDR_W    destination register
//  instr_rs1    in   ADDR_W    source A
//  instr_rs2    in   ADDR_W    source B
//  instr_imm    in   DATA_W    immediate, used by LDI only
//  rf_raddr_a   out  ADDR_W    register-file read address A
//  rf_raddr_b   out  ADDR_W    register-file read address B
//  opnd_le      out  1         latch ALU operands (READ cycle)
//  alu_op       out  3         opcode presented to the ALU (EXEC cycle)
//  res_le       out  1         latch ALU result (EXEC cycle)
//  alu_z        in   1         ALU zero flag
//  alu_c        in   1         ALU carry/borrow flag
//  flag_z       out  1         captured zero flag
//  flag_c       out  1         captured carry flag
//  wb_src       out  1         write-back mux select: 0 = ALU result, 1 = wb_imm
//  wb_imm       out  DATA_W    registered immediate
//  rf_wsel      out  NUM_REGS  one-hot register write select (WB cycle only)
//  done         out  1         1-cycle pulse when the instruction retires
// BEHAVIOUR
//  Opcodes:
//  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR: rd = rs1 op rs2.
//  - 101 NOT: rd = ~rs1; rs2 is ignored.
//  - 110 CMP: computes rs1 - rs2 and updates flags only; no register write.
//  - 111 LDI: rd = imm.
//  FSM states: IDLE, READ, EXEC, WB. Outputs are a Moore decode of state plus the latched instruction.
//  Handshake:
//  - instr_ready = (state == IDLE) && !reset.
//  - Accept occurs on the edge where valid && ready; op, rd, rs1, rs2 and imm are latched on that edge.
//  - instr_valid is ignored whenever ready is 0; no instruction is dropped or queued.
//  Transitions:
//  - IDLE -> READ on accept; for LDI, IDLE -> WB.
//  - READ -> EXEC -> WB -> IDLE unconditionally.
//  Per-state outputs:
//  - READ: rf_raddr_a = rs1, rf_raddr_b = rs2, opnd_le = 1.
//  - EXEC: alu_op = op, res_le = 1. flag_z/flag_c load alu_z/alu_c on the edge leaving EXEC (all ALU ops, including CMP).
//  - WB: rf_wsel = one-hot(rd), except all zero for CMP. wb_src = 1 only for LDI. done = 1 for every opcode.
//  - All other cycles: rf_wsel, opnd_le, res_le and done are 0; raddr and alu_op are 0.
//  Latency:
//  - ALU ops and CMP: accept at edge 0, READ in cycle 1, EXEC in cycle 2, WB/done in cycle 3, ready again in cycle 4.
//  - LDI: WB/done in cycle 1, ready in cycle 2.
//  - Back-to-back: a new instruction can be accepted in the first cycle of IDLE after WB.
//  Width rules:
//  - rd >= NUM_REGS produces rf_wsel all zero; the instruction still retires with done.
//  - wb_imm holds its value until the next LDI is accepted.
//  Reset (reset priority over everything):
//  - While reset is high, rf_wsel, done, opnd_le, res_le and instr_ready are forced to 0 combinationally, so no write can occur during a reset cycle.
//  - On the reset edge: state = IDLE; flag_z = flag_c = 0; wb_imm = 0; latched instruction = 0.
//  - Reset mid-instruction abandons it; there is no done and no write.
// STRUCTURE
//  - Package alu_seq_pkg holds:
//    - opcode localparams (OP_ADD..OP_LDI);
//    - state encoding (S_IDLE = 2'd0, S_READ = 2'd1, S_EXEC = 2'd2, S_WB = 2'd3);
//    - an is_alu_write(op) helper.
//  - Sub-module onehot_dec (ADDR_W -> NUM_REGS, with an enable input) generates rf_wsel.
//  - Everything else lives in one always block for the FSM plus datapath-control registers, and one combinational decode.
// TESTING
//  1. ADD: reset 2 cycles, then ADD rd=2, rs1=0, rs2=1.
//     -> raddr 0/1 with opnd_le in cycle 1; alu_op=000 with res_le in cycle 2; rf_wsel=0100 and done in cycle 3; ready in cycle 4.
//  2. LDI: rd=3, imm=4'hA.
//     -> wb_src=1, wb_imm=A, rf_wsel=1000 and done in cycle 1; ready in cycle 2.
//  3. CMP: rs1=1, rs2=1 with alu_z=1, alu_c=0 held during EXEC.
//     -> flag_z=1 and flag_c=0 from cycle 3; rf_wsel=0000 in WB; done=1.
//  4. Back-to-back: valid held high with SUB then XOR.
//     -> ready low for 3 cycles; XOR accepted in cycle 4 exactly; no instruction lost; two done pulses 4 cycles apart.
//  5. Reset mid-operation: reset asserted during EXEC of OR rd=1.
//     -> no rf_wsel activity; no done; flags = 0; state IDLE; ready = 1 the cycle after reset drops.
//  6. Ignored valid: valid toggled while busy with different ops.
//     -> only the first op executes; rf_wsel is one-hot or zero every cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and decode definitions for the ALU instruction sequencer.
// Imported by the sequencer top and any datapath block that decodes the same opcodes.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // True for opcodes whose ALU result is written back to rd.
    function automatic logic is_alu_write(input logic [2:0] op);
        return (op != OP_CMP) && (op != OP_LDI);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_onehot_dec.sv
// Enabled binary-to-one-hot decoder for register-file write selects.
// Addresses with no matching output bit decode to all zero.
module onehot_dec #(
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4
) (
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign o_onehot[gi] = i_en && (i_addr == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer stepping the 4-bit ALU datapath through READ, EXEC and WB.
// Outputs are a Moore decode of state and the instruction latched at accept.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [2:0]          instr_op,
    input  logic [ADDR_W-1:0]   instr_rd,
    input  logic [ADDR_W-1:0]   instr_rs1,
    input  logic [ADDR_W-1:0]   instr_rs2,
    input  logic [DATA_W-1:0]   instr_imm,
    output logic [ADDR_W-1:0]   rf_raddr_a,
    output logic [ADDR_W-1:0]   rf_raddr_b,
    output logic                opnd_le,
    output logic [2:0]          alu_op,
    output logic                res_le,
    input  logic                alu_z,
    input  logic                alu_c,
    output logic                flag_z,
    output logic                flag_c,
    output logic                wb_src,
    output logic [DATA_W-1:0]   wb_imm,
    output logic [NUM_REGS-1:0] rf_wsel,
    output logic                done
);

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W-1:0]   r_rs1;
    logic [ADDR_W-1:0]   r_rs2;
    logic [DATA_W-1:0]   r_wb_imm;
    logic                r_flag_z;
    logic                r_flag_c;
    logic                w_ready;
    logic                w_accept;
    logic                w_wsel_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_wb_imm <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op  <= instr_op;
                r_rd  <= instr_rd;
                r_rs1 <= instr_rs1;
                r_rs2 <= instr_rs2;
                if (instr_op == OP_LDI) begin
                    r_wb_imm <= instr_imm;
                end
            end
            // Flags follow the ALU result of every op that passes through EXEC.
            if (r_state == S_EXEC) begin
                r_flag_z <= alu_z;
                r_flag_c <= alu_c;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_wsel_en    = 1'b0;
        rf_raddr_a   = '0;
        rf_raddr_b   = '0;
        opnd_le      = 1'b0;
        alu_op       = 3'd0;
        res_le       = 1'b0;
        wb_src       = 1'b0;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready  = !reset;
                w_accept = instr_valid && w_ready;
                if (w_accept) begin
                    w_state_next = (instr_op == OP_LDI) ? S_WB : S_READ;
                end
            end
            S_READ: begin
                rf_raddr_a   = r_rs1;
                rf_raddr_b   = r_rs2;
                opnd_le      = !reset;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_op       = r_op;
                res_le       = !reset;
                w_state_next = S_WB;
            end
            S_WB: begin
                // Reset gating here guarantees no register write in a reset cycle.
                w_wsel_en    = (is_alu_write(r_op) || (r_op == OP_LDI)) && !reset;
                wb_src       = (r_op == OP_LDI);
                done         = !reset;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    onehot_dec #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_wsel_dec (
        .i_en     (w_wsel_en),
        .i_addr   (r_rd),
        .o_onehot (rf_wsel)
    );

    assign instr_ready = w_ready;
    assign flag_z      = r_flag_z;
    assign flag_c      = r_flag_c;
    assign wb_imm      = r_wb_imm;

endmodule
